// File: rtl/mips_pkg.sv
// Shared MIPS decode constants and hazard sequencer state encoding.
// Used by the control unit and the hazard sequencer.
package mips_pkg;

    localparam int unsigned OPCODE_W = 6;
    localparam int unsigned FUNCT_W  = 6;
    localparam int unsigned REG_W    = 5;
    localparam int unsigned CNT_W    = 3;

    localparam logic [OPCODE_W-1:0] OP_RTYPE  = 6'b000000;
    localparam logic [OPCODE_W-1:0] OP_LW     = 6'b100011;
    localparam logic [OPCODE_W-1:0] OP_J      = 6'b000010;
    localparam logic [FUNCT_W-1:0]  FUNCT_MUL = 6'b011100;

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_MUL_WAIT = 1'b1
    } hz_state_e;

endpackage

// File: rtl/hazard_sequencer.sv
// Pipeline hazard sequencer: load-use stalls, branch/jump flushes and
// multi-cycle multiplier occupancy of EX. Outputs are combinational.
module hazard_sequencer
    import mips_pkg::*;
#(
    parameter int unsigned MUL_LATENCY = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] id_op_code,
    input  logic [FUNCT_W-1:0]  id_funct,
    input  logic [REG_W-1:0]    id_rs,
    input  logic [REG_W-1:0]    id_rt,
    input  logic                ex_mem_read,
    input  logic [REG_W-1:0]    ex_rt,
    input  logic                ex_branch_taken,
    output logic                stall_pc,
    output logic                stall_ifid,
    output logic                flush_ifid,
    output logic                flush_idex,
    output logic                mul_start,
    output logic                mul_busy
);

    hz_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic id_is_mul;
    logic id_is_jump;
    logic load_use;

    assign id_is_mul  = (id_op_code == OP_RTYPE) && (id_funct == FUNCT_MUL);
    assign id_is_jump = (id_op_code == OP_J);
    assign load_use   = ex_mem_read && (ex_rt != '0) &&
                        ((ex_rt == id_rs) || (ex_rt == id_rt));

    // Next-state and output decode; reset forces every output low.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        stall_pc   = 1'b0;
        stall_ifid = 1'b0;
        flush_ifid = 1'b0;
        flush_idex = 1'b0;
        mul_start  = 1'b0;
        mul_busy   = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (ex_branch_taken) begin
                    flush_ifid = 1'b1;
                    flush_idex = 1'b1;
                end else if (load_use) begin
                    stall_pc   = 1'b1;
                    stall_ifid = 1'b1;
                    flush_idex = 1'b1;
                end else if (id_is_mul) begin
                    mul_start = 1'b1;
                    state_d   = ST_MUL_WAIT;
                    cnt_d     = CNT_W'(MUL_LATENCY - 1);
                end else if (id_is_jump) begin
                    flush_ifid = 1'b1;
                end
            end
            ST_MUL_WAIT: begin
                // EX is held by the mul and ID is frozen: ID/EX hazards are moot.
                stall_pc   = 1'b1;
                stall_ifid = 1'b1;
                flush_idex = 1'b1;
                mul_busy   = 1'b1;
                cnt_d      = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase

        if (rst) begin
            stall_pc   = 1'b0;
            stall_ifid = 1'b0;
            flush_ifid = 1'b0;
            flush_idex = 1'b0;
            mul_start  = 1'b0;
            mul_busy   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_sequencer.sv
// Self-checking bench for hazard_sequencer (MUL_LATENCY = 4).
// Expected output vectors are queued per driven cycle and compared on sampling.
module tb_hazard_sequencer;

    logic       clk;
    logic       rst;
    logic [5:0] id_op_code;
    logic [5:0] id_funct;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       ex_mem_read;
    logic [4:0] ex_rt;
    logic       ex_branch_taken;
    logic       stall_pc;
    logic       stall_ifid;
    logic       flush_ifid;
    logic       flush_idex;
    logic       mul_start;
    logic       mul_busy;

    int errors = 0;
    int checks = 0;

    logic [5:0] exp_q[$];
    string      name_q[$];

    // Vector order: {stall_pc, stall_ifid, flush_ifid, flush_idex, mul_start, mul_busy}
    localparam logic [5:0] EXP_IDLE = 6'b000000;
    localparam logic [5:0] EXP_LU   = 6'b110100;
    localparam logic [5:0] EXP_BR   = 6'b001100;
    localparam logic [5:0] EXP_MUL  = 6'b000010;
    localparam logic [5:0] EXP_WAIT = 6'b110101;
    localparam logic [5:0] EXP_JMP  = 6'b001000;

    hazard_sequencer #(.MUL_LATENCY(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_op_code      (id_op_code),
        .id_funct        (id_funct),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .ex_mem_read     (ex_mem_read),
        .ex_rt           (ex_rt),
        .ex_branch_taken (ex_branch_taken),
        .stall_pc        (stall_pc),
        .stall_ifid      (stall_ifid),
        .flush_ifid      (flush_ifid),
        .flush_idex      (flush_idex),
        .mul_start       (mul_start),
        .mul_busy        (mul_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_in(input logic [5:0] op, input logic [5:0] fn,
                          input logic [4:0] rs, input logic [4:0] rt,
                          input logic mr, input logic [4:0] ert, input logic bt);
        id_op_code      = op;
        id_funct        = fn;
        id_rs           = rs;
        id_rt           = rt;
        ex_mem_read     = mr;
        ex_rt           = ert;
        ex_branch_taken = bt;
    endtask

    task automatic id_nop();  set_in(6'b000000, 6'b100000, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0); endtask
    task automatic id_mul();  set_in(6'b000000, 6'b011100, 5'd3, 5'd4, 1'b0, 5'd0, 1'b0); endtask
    task automatic id_jump(); set_in(6'b000010, 6'b000000, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0); endtask

    // Inputs are already applied; queue the expectation, sample mid-cycle, advance.
    task automatic step(input string name, input logic [5:0] exp);
        logic [5:0] got;
        logic [5:0] e;
        string      n;
        exp_q.push_back(exp);
        name_q.push_back(name);
        #2;
        got = {stall_pc, stall_ifid, flush_ifid, flush_idex, mul_start, mul_busy};
        e = exp_q.pop_front();
        n = name_q.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL %s: got %b expected %b", n, got, e);
        end
        checks++;
        if ((stall_ifid & flush_ifid) !== 1'b0) begin
            errors++;
            $display("FAIL %s_exclusive: stall_ifid=%b flush_ifid=%b expected not both 1",
                     n, stall_ifid, flush_ifid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_in(6'b000000, 6'b011100, 5'd8, 5'd8, 1'b1, 5'd8, 1'b1);
        step("reset_all_hazards", EXP_IDLE);
        set_in(6'b000010, 6'b000000, 5'd8, 5'd0, 1'b1, 5'd8, 1'b0);
        step("reset_jump_lu", EXP_IDLE);
        rst = 1'b0;
        id_nop();
        step("reset_release_idle", EXP_IDLE);
    endtask

    task automatic test_load_use();
        set_in(6'b000000, 6'b100000, 5'd8, 5'd9, 1'b1, 5'd8, 1'b0);
        step("lu_rs_stall", EXP_LU);
        set_in(6'b000000, 6'b100000, 5'd8, 5'd9, 1'b0, 5'd0, 1'b0);
        step("lu_rs_after", EXP_IDLE);
        set_in(6'b000000, 6'b100000, 5'd5, 5'd17, 1'b1, 5'd17, 1'b0);
        step("lu_rt_stall", EXP_LU);
        id_nop();
        step("lu_rt_after", EXP_IDLE);
        set_in(6'b000000, 6'b100000, 5'd0, 5'd9, 1'b1, 5'd0, 1'b0);
        step("lu_zero_reg", EXP_IDLE);
        set_in(6'b000000, 6'b100000, 5'd7, 5'd9, 1'b1, 5'd8, 1'b0);
        step("lu_no_match", EXP_IDLE);
    endtask

    task automatic test_mul();
        id_mul();
        step("mul_start", EXP_MUL);
        step("mul_wait1", EXP_WAIT);
        step("mul_wait2", EXP_WAIT);
        step("mul_wait3", EXP_WAIT);
        id_nop();
        step("mul_done", EXP_IDLE);
    endtask

    task automatic test_priority();
        set_in(6'b000000, 6'b011100, 5'd8, 5'd9, 1'b1, 5'd8, 1'b1);
        step("prio_branch", EXP_BR);
        id_nop();
        step("prio_branch_after", EXP_IDLE);
        set_in(6'b000000, 6'b011100, 5'd8, 5'd9, 1'b1, 5'd8, 1'b0);
        step("prio_lu_over_mul", EXP_LU);
        id_nop();
        step("prio_lu_after", EXP_IDLE);
        set_in(6'b000000, 6'b011100, 5'd3, 5'd4, 1'b0, 5'd0, 1'b1);
        step("prio_branch_over_mul", EXP_BR);
        id_nop();
        step("prio_branch_mul_after", EXP_IDLE);
    endtask

    task automatic test_jump();
        id_jump();
        step("jump_flush", EXP_JMP);
        id_nop();
        step("jump_after", EXP_IDLE);
        id_mul();
        step("jump_mw_start", EXP_MUL);
        id_jump();
        step("jump_mw_wait1", EXP_WAIT);
        set_in(6'b000010, 6'b000000, 5'd8, 5'd8, 1'b1, 5'd8, 1'b1);
        step("jump_mw_wait2_hazards", EXP_WAIT);
        id_jump();
        step("jump_mw_wait3", EXP_WAIT);
        step("jump_mw_run", EXP_JMP);
        id_nop();
        step("jump_mw_idle", EXP_IDLE);
    endtask

    task automatic test_back_to_back();
        id_mul();
        step("b2b_start1", EXP_MUL);
        step("b2b_wait1a", EXP_WAIT);
        step("b2b_wait1b", EXP_WAIT);
        step("b2b_wait1c", EXP_WAIT);
        step("b2b_start2", EXP_MUL);
        step("b2b_wait2a", EXP_WAIT);
        step("b2b_wait2b", EXP_WAIT);
        step("b2b_wait2c", EXP_WAIT);
        id_nop();
        step("b2b_idle", EXP_IDLE);
    endtask

    task automatic test_reset_mid_mul();
        id_mul();
        step("rmm_start", EXP_MUL);
        step("rmm_wait1", EXP_WAIT);
        rst = 1'b1;
        step("rmm_reset_wait2", EXP_IDLE);
        rst = 1'b0;
        id_nop();
        step("rmm_run_after_reset", EXP_IDLE);
        id_mul();
        step("rmm_relaunch", EXP_MUL);
        step("rmm_rwait1", EXP_WAIT);
        step("rmm_rwait2", EXP_WAIT);
        step("rmm_rwait3", EXP_WAIT);
        id_nop();
        step("rmm_idle", EXP_IDLE);
    endtask

    initial begin
        rst = 1'b1;
        id_nop();
        @(posedge clk);
        #1;
        test_reset();
        test_load_use();
        test_mul();
        test_priority();
        test_jump();
        test_back_to_back();
        test_reset_mid_mul();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_sequencer.md
HAZARD_SEQUENCER -- requirements
Module: hazard_sequencer

Interface
REQ-001 Parameter: MUL_LATENCY, default 4, EX-stage cycles a mul occupies (legal 2..8).
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 id_op_code  in  6  opcode of instruction in ID.
REQ-005 id_funct  in  6  funct field of instruction in ID.
REQ-006 id_rs, id_rt  in  5 each  source register numbers in ID.
REQ-007 ex_mem_read  in  1  instruction in EX is a load word.
REQ-008 ex_rt  in  5  destination register of the load in EX.
REQ-009 ex_branch_taken  in  1  branch in EX resolved taken this cycle.
REQ-010 stall_pc  out  1  hold PC.
REQ-011 stall_ifid  out  1  hold IF/ID register.
REQ-012 flush_ifid  out  1  zero IF/ID register.
REQ-013 flush_idex  out  1  insert bubble into ID/EX.
REQ-014 mul_start  out  1  one-cycle launch pulse for the multiplier.
REQ-015 mul_busy  out  1  multiplier occupying EX.

Function
REQ-016 States: RUN, MUL_WAIT. 3-bit down-counter cnt. State and cnt are registered; all outputs are combinational from state, cnt and inputs.
REQ-017 Decodes: id_is_mul = (id_op_code==000000 && id_funct==011100); id_is_jump = (id_op_code==000010).
REQ-018 load_use = ex_mem_read && ex_rt!=0 && (ex_rt==id_rs || ex_rt==id_rt).
REQ-019 RUN, priority 1: ex_branch_taken -> flush_ifid=1, flush_idex=1, no stall, no mul_start, stay RUN.
REQ-020 RUN, priority 2: load_use -> stall_pc=1, stall_ifid=1, flush_idex=1, mul_start=0, stay RUN (one bubble per hazard).
REQ-021 RUN, priority 3: id_is_mul -> mul_start=1 that cycle, next state MUL_WAIT, cnt<=MUL_LATENCY-1.
REQ-022 RUN, priority 4: id_is_jump -> flush_ifid=1 only.
REQ-023 RUN with none of the above: all outputs 0.
REQ-024 MUL_WAIT: stall_pc=1, stall_ifid=1, flush_idex=1, mul_busy=1, mul_start=0.
REQ-025 MUL_WAIT: cnt decrements each cycle. When cnt==1 the next state is RUN, so the total stall is MUL_LATENCY-1 cycles after the mul_start cycle.
REQ-026 MUL_WAIT ignores ex_branch_taken, load_use, id_is_mul and id_is_jump (EX holds the mul; ID is frozen).
REQ-027 Back-to-back mul: a mul reaching ID in the first RUN cycle after MUL_WAIT launches immediately per REQ-021.
REQ-028 flush_ifid and stall_ifid are never both 1 in the same cycle.

Reset
REQ-029 While rst=1, every output is 0 regardless of inputs.
REQ-030 On a clock edge with rst=1, state<=RUN and cnt<=0, including mid-MUL_WAIT. No pending mul is resumed.

Structure
REQ-031 The opcode/funct constants (load word, jump, r-type, mul) and the state encoding live in a shared package, mips_pkg, that is also used by the control unit.
REQ-032 No sub-module; the counter and FSM are inline.

Verification
REQ-033 lw $t0 in EX (ex_mem_read=1, ex_rt=8) with id_rs=8 -> exactly 1 cycle of stall_pc=stall_ifid=flush_idex=1, then all outputs 0.
REQ-034 Same as REQ-033 with ex_rt=0 -> no stall.
REQ-035 ID holds mul, MUL_LATENCY=4 -> mul_start for 1 cycle, then mul_busy/stall for 3 cycles, then RUN.
REQ-036 ex_branch_taken=1 together with load_use=1 and id_is_mul=1 -> flush_ifid=flush_idex=1, mul_start=0, stall=0.
REQ-037 rst asserted in the 2nd MUL_WAIT cycle -> outputs 0 that cycle; RUN with cnt=0 next cycle; a mul then in ID relaunches normally.
REQ-038 ID holds a jump in RUN -> flush_ifid=1 for 1 cycle only. A jump present during MUL_WAIT -> no flush.
